simple_reset_seq: RTL and testbench
===================================

Name: simple_reset_seq

Overview:
- Reset-release counterpart to the team's async/sync reset flops. It consumes a raw asynchronous reset and drives the reset pins of downstream flops.
- Reset assertion is immediate and asynchronous. Release is synchronous to CK, held for a minimum time, then staggered across NUM_OUT domains.
- A global clock enable is granted only once the whole sequence completes.
- Sits at the top of each clock domain, between the board/PLL reset and the SR/CE pins of the domain logic.

Parameters:
- SYNC_STAGES, 2, synchronizer flop count on the deassert path; must be >= 2.
- NUM_OUT, 3, number of staged reset outputs; must be >= 1.
- MIN_ASSERT, 8, CK edges resets stay held after the synchronized release; must be >= 1.
- STAGE_DLY, 16, CK edges between consecutive output releases; must be >= 1.

Ports:
- CK  input  1  clock.
- SR  input  1  asynchronous, active-high reset.
- SW_RST  input  1  synchronous soft-reset request, sampled on CK, active-high.
- RST_OUT  output  NUM_OUT  active-high resets to downstream domains; bit 0 releases first.
- CE_OUT  output  1  global clock enable to downstream logic.
- DONE  output  1  sequence complete.
- BUSY  output  1  sequence in progress (HOLD or STAGE).

Behaviour:
- Clock and reset: one clock, CK. Reset SR is asynchronous and active-high.
- SR assertion, at any time including mid-sequence, does all of the following without waiting for CK:
  - RST_OUT = all ones, CE_OUT = 0, DONE = 0, BUSY = 0.
  - Synchronizer chain is set to 1s.
  - FSM goes to RESET and all counters clear.
- Edge numbering: "edge n" is the nth rising CK after SR deasserts, meeting recovery time.
- Synchronizer: SR deassertion propagates through SYNC_STAGES flops. The internal synchronized reset is low after edge SYNC_STAGES. Only this internal signal feeds the FSM.
- FSM states: RESET, HOLD, STAGE, DONE.
  - RESET -> HOLD when the synchronized reset is low. Counter starts at 0 after edge SYNC_STAGES. BUSY = 1.
  - HOLD: counts MIN_ASSERT edges. RST_OUT[0] falls after edge SYNC_STAGES+MIN_ASSERT, then STAGE with stage index 1.
  - STAGE: each further STAGE_DLY edges, the next RST_OUT bit falls. RST_OUT[k] falls after edge SYNC_STAGES+MIN_ASSERT+k*STAGE_DLY.
    - When the last bit falls: enter DONE on the same edge, DONE = 1, BUSY = 0.
    - If NUM_OUT = 1, HOLD goes directly to DONE.
  - DONE: CE_OUT rises one edge after DONE rises. All outputs stay static until SW_RST or SR.
- Release order: bits are released strictly in index order. A released bit stays low until the next reset event.
- SW_RST, sampled high at edge e (SR low, any state except RESET):
  - After edge e: RST_OUT = all ones, CE_OUT = 0, DONE = 0, BUSY = 1.
  - FSM goes to HOLD with counter 0.
  - RST_OUT[0] falls after edge e+MIN_ASSERT. Later stages follow the same spacing as above.
- SW_RST mid-sequence, in HOLD or STAGE: restarts the sequence from HOLD as above.
- SW_RST held high: the sequence restarts every cycle. Outputs stay asserted until SW_RST falls.
- SW_RST in RESET: ignored.
- SR and SW_RST together: SR dominates.
- Counter width: $clog2(max(MIN_ASSERT, STAGE_DLY)+1). The stage index is $clog2(NUM_OUT+1) bits. No wrap is reachable; counters reset on every state entry.
- Glitch-free outputs: every output comes directly from a flop, with no combinational output logic.
- Elaboration checks: illegal parameter values (below the stated minimums) produce a fatal error.

Decomposition:
- Package simple_reset_pkg:
  - enum type for states RESET, HOLD, STAGE, DONE;
  - localparam helper for counter width.
- Sub-module simple_reset_sync:
  - parameters SYNC_STAGES;
  - ports CK, SR in, synchronized reset out;
  - async set of all stages, shift of 0 on deassert.

Test Plan (defaults: SYNC_STAGES=2, MIN_ASSERT=8, STAGE_DLY=16, NUM_OUT=3):
- Power-up: SR=1 for 5 cycles, then 0.
  - RST_OUT=3'b111 throughout SR.
  - RST_OUT becomes 3'b110 after edge 10, 3'b100 after edge 26, 3'b000 after edge 42.
  - DONE=1 after edge 42; CE_OUT=1 after edge 43; BUSY=1 from edge 2 until edge 42.
- Async assert: wait for DONE, then pulse SR high between CK edges for 3 ns.
  - RST_OUT=3'b111, CE_OUT=0, DONE=0 before the next CK edge.
  - Sequence repeats with identical timing measured from the SR fall.
- Soft reset in DONE: SW_RST pulse at edge e.
  - After e: RST_OUT=3'b111, BUSY=1, CE_OUT=0.
  - RST_OUT[0] falls after e+8, RST_OUT[1] after e+24, RST_OUT[2] after e+40.
- Soft reset mid-stage: SW_RST at edge 30, when RST_OUT=3'b100.
  - RST_OUT returns to 3'b111 after edge 30.
  - RST_OUT[0] falls after edge 38; DONE after edge 70.
- Reset during HOLD: SR asserted at edge 6.
  - Immediate all-asserted outputs.
  - No early release: from the new SR fall, RST_OUT[0] falls exactly after edge 10.
- SW_RST held high for 20 cycles from DONE: RST_OUT stays 3'b111 for all 20 cycles; release timing is measured from the last sampled-high edge.

Source files
------------

// File: rtl/simple_reset_pkg.sv
// Shared types for the reset-release sequencer.
// Holds the FSM state enum and the counter-width helper.
package simple_reset_pkg;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_HOLD,
    ST_STAGE,
    ST_DONE
  } state_t;

  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/simple_reset_sync.sv
// Reset deassert synchronizer: async set, shifts 0 in on CK.
// Ports: CK, SR (async set), o_srst (synced), o_srst_nxt (its next value).
module simple_reset_sync
  #(parameter int SYNC_STAGES = 2)
  (
    input  logic CK,
    input  logic SR,
    output logic o_srst,
    output logic o_srst_nxt
  );

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge CK or posedge SR) begin
    if (SR) r_sync <= '1;
    else    r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
  end

  assign o_srst     = r_sync[SYNC_STAGES-1];
  // Value o_srst takes at the next edge; lets the FSM leave
  // RESET on the same edge the synchronized reset clears.
  assign o_srst_nxt = r_sync[SYNC_STAGES-2];

endmodule

// File: rtl/simple_reset_seq.sv
// Reset sequencer: async assert, synced hold, staggered release, CE.
// Ports: CK, SR, SW_RST in; RST_OUT, CE_OUT, DONE, BUSY out (all flops).
module simple_reset_seq
  import simple_reset_pkg::*;
  #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_OUT     = 3,
    parameter int MIN_ASSERT  = 8,
    parameter int STAGE_DLY   = 16
  )
  (
    input  logic               CK,
    input  logic               SR,
    input  logic               SW_RST,
    output logic [NUM_OUT-1:0] RST_OUT,
    output logic               CE_OUT,
    output logic               DONE,
    output logic               BUSY
  );

  localparam int CW = cnt_w(MIN_ASSERT, STAGE_DLY);
  localparam int IW = $clog2(NUM_OUT + 1);
  localparam logic [NUM_OUT-1:0] ONES = '1;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "SYNC_STAGES must be >= 2");
  end
  if (NUM_OUT < 1) begin : g_bad_num
    $fatal(1, "NUM_OUT must be >= 1");
  end
  if (MIN_ASSERT < 1) begin : g_bad_min
    $fatal(1, "MIN_ASSERT must be >= 1");
  end
  if (STAGE_DLY < 1) begin : g_bad_dly
    $fatal(1, "STAGE_DLY must be >= 1");
  end

  logic w_srst;
  logic w_srst_nxt;
  logic w_sw;
  logic w_last;
  logic w_tc;

  state_t             r_state, w_state;
  logic [CW-1:0]      r_cnt,   w_cnt;
  logic [IW-1:0]      r_idx,   w_idx;
  logic [NUM_OUT-1:0] r_rst,   w_rst;
  logic               r_ce,    w_ce;
  logic               r_done,  w_done;
  logic               r_busy,  w_busy;

  simple_reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CK         (CK),
    .SR         (SR),
    .o_srst     (w_srst),
    .o_srst_nxt (w_srst_nxt)
  );

  // Soft reset is honoured only once the domain is out of RESET.
  assign w_sw   = SW_RST & ~w_srst & (r_state != ST_RESET);
  assign w_last = (r_idx == IW'(NUM_OUT - 1));

  always_comb begin
    w_tc = 1'b0;
    unique case (r_state)
      ST_HOLD:  w_tc = (r_cnt == CW'(MIN_ASSERT - 1));
      ST_STAGE: w_tc = (r_cnt == CW'(STAGE_DLY - 1));
      default:  w_tc = 1'b0;
    endcase
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_rst   = r_rst;
    w_ce    = r_ce;
    w_done  = r_done;
    w_busy  = r_busy;
    unique case (r_state)
      ST_RESET: begin
        if (!w_srst_nxt) begin
          w_state = ST_HOLD;
          w_cnt   = '0;
          w_idx   = '0;
          w_busy  = 1'b1;
        end
      end
      ST_HOLD, ST_STAGE: begin
        if (w_tc) begin
          // Bits release in index order: keep only those above r_idx.
          w_rst = ONES << (r_idx + 1'b1);
          w_cnt = '0;
          if (w_last) begin
            w_state = ST_DONE;
            w_done  = 1'b1;
            w_busy  = 1'b0;
          end else begin
            w_state = ST_STAGE;
            w_idx   = r_idx + 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ST_DONE: w_ce = 1'b1;
      default: w_state = ST_RESET;
    endcase
    if (w_sw) begin
      w_state = ST_HOLD;
      w_cnt   = '0;
      w_idx   = '0;
      w_rst   = ONES;
      w_ce    = 1'b0;
      w_done  = 1'b0;
      w_busy  = 1'b1;
    end
  end

  always_ff @(posedge CK or posedge SR) begin
    if (SR) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst   <= ONES;
      r_ce    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_rst   <= w_rst;
      r_ce    <= w_ce;
      r_done  <= w_done;
      r_busy  <= w_busy;
    end
  end

  assign RST_OUT = r_rst;
  assign CE_OUT  = r_ce;
  assign DONE    = r_done;
  assign BUSY    = r_busy;

endmodule

// File: tb/tb_simple_reset_seq.sv
// Directed bench for simple_reset_seq with default parameters.
// Edge e counts rising CK edges since the last SR fall or restart.
module tb_simple_reset_seq;

  logic       CK = 1'b0;
  logic       SR = 1'b0;
  logic       SW_RST = 1'b0;
  logic [2:0] RST_OUT;
  logic       CE_OUT;
  logic       DONE;
  logic       BUSY;

  int n_vec = 0;
  int n_bad = 0;
  int e = 0;

  simple_reset_seq #(
    .SYNC_STAGES (2),
    .NUM_OUT     (3),
    .MIN_ASSERT  (8),
    .STAGE_DLY   (16)
  ) dut (
    .CK      (CK),
    .SR      (SR),
    .SW_RST  (SW_RST),
    .RST_OUT (RST_OUT),
    .CE_OUT  (CE_OUT),
    .DONE    (DONE),
    .BUSY    (BUSY)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
    e++;
  endtask

  // Expected outputs at edge k for a sequence whose HOLD begins at t0:
  // releases at t0+8, t0+24, t0+40; CE one edge after DONE.
  function automatic logic [2:0] x_rst(input int k, input int t0);
    if (k < t0 + 8)  return 3'b111;
    if (k < t0 + 24) return 3'b110;
    if (k < t0 + 40) return 3'b100;
    return 3'b000;
  endfunction

  task automatic chk_now(input int t0);
    chk($sformatf("rst@%0d", e), 8'(RST_OUT), 8'(x_rst(e, t0)));
    chk($sformatf("busy@%0d", e), 8'(BUSY),
        8'((e >= t0) && (e < t0 + 40)));
    chk($sformatf("done@%0d", e), 8'(DONE), 8'(e >= t0 + 40));
    chk($sformatf("ce@%0d", e), 8'(CE_OUT), 8'(e >= t0 + 41));
  endtask

  task automatic span(input int t0, input int upto);
    while (e < upto) begin
      tick();
      chk_now(t0);
    end
  endtask

  task automatic chk_asserted(input string tag);
    chk({tag, "_rst"},  8'(RST_OUT), 8'h07);
    chk({tag, "_ce"},   8'(CE_OUT),  8'h00);
    chk({tag, "_done"}, 8'(DONE),    8'h00);
    chk({tag, "_busy"}, 8'(BUSY),    8'h00);
  endtask

  // 3 ns SR pulse placed between edges; restarts edge numbering.
  task automatic sr_pulse(input string tag);
    SR = 1'b1;
    #2;
    chk_asserted(tag);
    #1;
    SR = 1'b0;
    e = 0;
  endtask

  initial begin
    int t0;
    #1 SR = 1'b1;
    // Power-up: SR held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(posedge CK);
      #1;
      chk_asserted($sformatf("por%0d", i));
    end
    #1 SR = 1'b0;
    e = 0;
    chk_now(2);
    span(2, 45);

    // Async assert from DONE, then identical re-sequence.
    sr_pulse("async");
    chk_now(2);
    span(2, 45);

    // Soft reset in DONE sampled at edge 46.
    SW_RST = 1'b1;
    tick();
    SW_RST = 1'b0;
    chk_now(46);
    span(46, 46 + 42);

    // Soft reset mid-stage at edge 30 of a fresh sequence.
    sr_pulse("pre_mid");
    span(2, 29);
    SW_RST = 1'b1;
    tick();
    SW_RST = 1'b0;
    chk_now(30);
    span(30, 72);

    // SR during HOLD at edge 6: no early release afterwards.
    sr_pulse("pre_hold");
    span(2, 6);
    sr_pulse("hold");
    chk_now(2);
    span(2, 45);

    // SW_RST held high for 20 cycles from DONE.
    SW_RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("swh_rst%0d", i),  8'(RST_OUT), 8'h07);
      chk($sformatf("swh_busy%0d", i), 8'(BUSY),    8'h01);
      chk($sformatf("swh_ce%0d", i),   8'(CE_OUT),  8'h00);
    end
    SW_RST = 1'b0;
    t0 = e;
    span(t0, t0 + 42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
